// File: rtl/dual_issue_ctrl_pkg.sv
// Shared widths, state encoding and dependency qualification for the dual-issue pairing stage.
package dual_issue_ctrl_pkg;

  localparam int unsigned DI_IWIDTH = 32;
  localparam int unsigned DI_AWIDTH = 5;

  typedef enum logic {
    DiNormal = 1'b0,
    DiSplit  = 1'b1
  } di_state_e;

  // A dependency only matters when both instructions are live and instr1 writes a real register.
  function automatic logic qual_dep(input logic change, input logic valid_1, input logic valid_2,
                                    input logic rd_nonzero);
    return change & valid_1 & valid_2 & rd_nonzero;
  endfunction

endpackage

// File: rtl/dual_issue_hold.sv
// Single-entry hold register parking instr2 of a split pair until slot0 frees up.
module dual_issue_hold
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned IWIDTH = DI_IWIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [IWIDTH-1:0] i_instr,
  input  logic [IWIDTH-1:0] i_pc,
  output logic              o_valid,
  output logic [IWIDTH-1:0] o_instr,
  output logic [IWIDTH-1:0] o_pc
);

  logic              r_valid;
  logic [IWIDTH-1:0] r_instr;
  logic [IWIDTH-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/dual_issue_ctrl.sv
// Pairing/issue register stage: issues independent pairs together, splits dependent pairs
// over two cycles while back-pressuring fetch, and counts split events.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned IWIDTH = DI_IWIDTH,
  parameter int unsigned AWIDTH = DI_AWIDTH,
  parameter int unsigned CWIDTH = 16
) (
  input  logic              di_i_clk,
  input  logic              di_i_rst,
  input  logic              di_i_flush,
  input  logic              di_i_valid_1,
  input  logic              di_i_valid_2,
  input  logic [IWIDTH-1:0] di_i_instr_1,
  input  logic [IWIDTH-1:0] di_i_pc_1,
  input  logic [IWIDTH-1:0] di_i_instr_2,
  input  logic [IWIDTH-1:0] di_i_pc_2,
  input  logic [AWIDTH-1:0] di_i_addr_rd_1,
  input  logic              di_i_change_instr,
  input  logic              di_i_ready,
  output logic              di_o_ready,
  output logic              di_o_valid_0,
  output logic [IWIDTH-1:0] di_o_instr_0,
  output logic [IWIDTH-1:0] di_o_pc_0,
  output logic              di_o_valid_1,
  output logic [IWIDTH-1:0] di_o_instr_1,
  output logic [IWIDTH-1:0] di_o_pc_1,
  output logic [CWIDTH-1:0] di_o_split_cnt
);

  di_state_e         r_state_q, r_state_d;
  logic              r_v0_q, r_v0_d;
  logic              r_v1_q, r_v1_d;
  logic [IWIDTH-1:0] r_instr0_q, r_instr0_d;
  logic [IWIDTH-1:0] r_pc0_q, r_pc0_d;
  logic [IWIDTH-1:0] r_instr1_q, r_instr1_d;
  logic [IWIDTH-1:0] r_pc1_q, r_pc1_d;
  logic [CWIDTH-1:0] r_cnt_q, r_cnt_d;

  logic              w_ready;
  logic              w_accept;
  logic              w_dep;
  logic              w_hold_load;
  logic              w_hold_clear;
  logic              w_hold_valid;
  logic [IWIDTH-1:0] w_hold_instr;
  logic [IWIDTH-1:0] w_hold_pc;

  assign w_ready  = (r_state_q == DiNormal) & di_i_ready & ~di_i_flush;
  assign w_accept = w_ready & (di_i_valid_1 | di_i_valid_2);
  assign w_dep    = qual_dep(di_i_change_instr, di_i_valid_1, di_i_valid_2,
                             di_i_addr_rd_1 != '0);

  dual_issue_hold #(
    .IWIDTH(IWIDTH)
  ) u_hold (
    .i_clk  (di_i_clk),
    .i_rst  (di_i_rst),
    .i_load (w_hold_load),
    .i_clear(w_hold_clear),
    .i_instr(di_i_instr_2),
    .i_pc   (di_i_pc_2),
    .o_valid(w_hold_valid),
    .o_instr(w_hold_instr),
    .o_pc   (w_hold_pc)
  );

  always_comb begin
    r_state_d    = r_state_q;
    r_v0_d       = r_v0_q;
    r_v1_d       = r_v1_q;
    r_instr0_d   = r_instr0_q;
    r_pc0_d      = r_pc0_q;
    r_instr1_d   = r_instr1_q;
    r_pc1_d      = r_pc1_q;
    r_cnt_d      = r_cnt_q;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;

    if (di_i_flush) begin
      r_v0_d       = 1'b0;
      r_v1_d       = 1'b0;
      r_state_d    = DiNormal;
      w_hold_clear = 1'b1;
    end else if (di_i_ready) begin
      unique case (r_state_q)
        DiNormal: begin
          if (w_accept && w_dep) begin
            r_v0_d      = 1'b1;
            r_instr0_d  = di_i_instr_1;
            r_pc0_d     = di_i_pc_1;
            r_v1_d      = 1'b0;
            w_hold_load = 1'b1;
            r_state_d   = DiSplit;
            if (r_cnt_q != {CWIDTH{1'b1}}) r_cnt_d = r_cnt_q + CWIDTH'(1);
          end else if (w_accept && di_i_valid_1) begin
            r_v0_d     = 1'b1;
            r_instr0_d = di_i_instr_1;
            r_pc0_d    = di_i_pc_1;
            r_v1_d     = di_i_valid_2;
            r_instr1_d = di_i_instr_2;
            r_pc1_d    = di_i_pc_2;
          end else if (w_accept) begin
            // A lone instr2 is still the oldest live instruction, so it takes slot0.
            r_v0_d     = 1'b1;
            r_instr0_d = di_i_instr_2;
            r_pc0_d    = di_i_pc_2;
            r_v1_d     = 1'b0;
          end else begin
            r_v0_d = 1'b0;
            r_v1_d = 1'b0;
          end
        end
        DiSplit: begin
          r_v0_d       = w_hold_valid;
          r_instr0_d   = w_hold_instr;
          r_pc0_d      = w_hold_pc;
          r_v1_d       = 1'b0;
          w_hold_clear = 1'b1;
          r_state_d    = DiNormal;
        end
        default: r_state_d = DiNormal;
      endcase
    end
  end

  always_ff @(posedge di_i_clk) begin
    if (di_i_rst) begin
      r_state_q  <= DiNormal;
      r_v0_q     <= 1'b0;
      r_v1_q     <= 1'b0;
      r_instr0_q <= '0;
      r_pc0_q    <= '0;
      r_instr1_q <= '0;
      r_pc1_q    <= '0;
      r_cnt_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      r_v0_q     <= r_v0_d;
      r_v1_q     <= r_v1_d;
      r_instr0_q <= r_instr0_d;
      r_pc0_q    <= r_pc0_d;
      r_instr1_q <= r_instr1_d;
      r_pc1_q    <= r_pc1_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  assign di_o_ready     = w_ready;
  assign di_o_valid_0   = r_v0_q;
  assign di_o_instr_0   = r_instr0_q;
  assign di_o_pc_0      = r_pc0_q;
  assign di_o_valid_1   = r_v1_q;
  assign di_o_instr_1   = r_instr1_q;
  assign di_o_pc_1      = r_pc1_q;
  assign di_o_split_cnt = r_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl: queue-based issue model checked every cycle, plus
// hand-computed literal checks on the key scenarios.
module tb_dual_issue_ctrl;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [IW-1:0] pc;
  } ins_t;

  logic          clk = 1'b0;
  logic          rst, flush, v1, v2, chg, rdy;
  logic [IW-1:0] i1, p1, i2, p2;
  logic [AW-1:0] rd;
  logic          o_ready, o_v0, o_v1;
  logic [IW-1:0] o_i0, o_p0, o_i1, o_p1;
  logic [CW-1:0] o_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: what each slot must show, and instructions waiting to issue.
  logic          model_ok = 1'b0;
  logic          ev0, ev1;
  ins_t          es0, es1;
  ins_t          pend[$];
  int unsigned   ecnt;

  always #5 clk = ~clk;

  dual_issue_ctrl #(
    .IWIDTH(IW),
    .AWIDTH(AW),
    .CWIDTH(CW)
  ) dut (
    .di_i_clk         (clk),
    .di_i_rst         (rst),
    .di_i_flush       (flush),
    .di_i_valid_1     (v1),
    .di_i_valid_2     (v2),
    .di_i_instr_1     (i1),
    .di_i_pc_1        (p1),
    .di_i_instr_2     (i2),
    .di_i_pc_2        (p2),
    .di_i_addr_rd_1   (rd),
    .di_i_change_instr(chg),
    .di_i_ready       (rdy),
    .di_o_ready       (o_ready),
    .di_o_valid_0     (o_v0),
    .di_o_instr_0     (o_i0),
    .di_o_pc_0        (o_p0),
    .di_o_valid_1     (o_v1),
    .di_o_instr_1     (o_i1),
    .di_o_pc_1        (o_p1),
    .di_o_split_cnt   (o_cnt)
  );

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk_instr(input logic [IW-1:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  // One clock of the model, from the inputs seen at this edge.
  task automatic model_step();
    ins_t lst[$];
    if (rst) begin
      model_ok = 1'b1;
      ev0 = 1'b0; ev1 = 1'b0; es0 = '0; es1 = '0;
      pend.delete();
      ecnt = 0;
    end else if (flush) begin
      ev0 = 1'b0; ev1 = 1'b0;
      pend.delete();
    end else if (!rdy) begin
      // stalled: nothing moves
    end else if (pend.size() > 0) begin
      es0 = pend.pop_front(); ev0 = 1'b1; ev1 = 1'b0;
    end else begin
      if (v1) lst.push_back('{instr: i1, pc: p1});
      if (v2) lst.push_back('{instr: i2, pc: p2});
      if (lst.size() == 0) begin
        ev0 = 1'b0; ev1 = 1'b0;
      end else if (v1 && v2 && chg && rd != 0) begin
        es0 = lst[0]; ev0 = 1'b1; ev1 = 1'b0;
        pend.push_back(lst[1]);
        if (ecnt < (1 << CW) - 1) ecnt++;
      end else begin
        es0 = lst[0]; ev0 = 1'b1;
        ev1 = (lst.size() == 2);
        if (ev1) es1 = lst[1];
      end
    end
  endtask

  task automatic model_cmp();
    if (!model_ok) return;
    chk("m.valid_0", {31'b0, o_v0}, {31'b0, ev0});
    chk("m.valid_1", {31'b0, o_v1}, {31'b0, ev1});
    if (ev0) begin
      chk("m.pc_0", o_p0, es0.pc);
      chk("m.instr_0", o_i0, es0.instr);
    end
    if (ev1) begin
      chk("m.pc_1", o_p1, es1.pc);
      chk("m.instr_1", o_i1, es1.instr);
    end
    chk("m.split_cnt", IW'(o_cnt), IW'(ecnt));
    chk("m.o_ready", {31'b0, o_ready}, {31'b0, (pend.size() == 0) && rdy && !flush});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic set_pair(input logic a, input logic b, input logic [IW-1:0] pa,
                          input logic [IW-1:0] pb, input logic [AW-1:0] r, input logic c);
    v1 = a; v2 = b; p1 = pa; p2 = pb; i1 = mk_instr(pa); i2 = mk_instr(pb);
    rd = r; chg = c; rdy = 1'b1; flush = 1'b0;
  endtask

  task automatic idle();
    set_pair(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst.valid_0", {31'b0, o_v0}, 32'd0);
    chk("rst.valid_1", {31'b0, o_v1}, 32'd0);
    chk("rst.pc_0", o_p0, 32'd0);
    chk("rst.instr_0", o_i0, 32'd0);
    chk("rst.pc_1", o_p1, 32'd0);
    chk("rst.cnt", IW'(o_cnt), 32'd0);
    chk("rst.ready", {31'b0, o_ready}, 32'd1);
    rst = 1'b0;

    // Independent pair
    set_pair(1'b1, 1'b1, 32'h100, 32'h104, 5'd5, 1'b0);
    tick();
    idle(); #1;
    chk("ind.valid_0", {31'b0, o_v0}, 32'd1);
    chk("ind.valid_1", {31'b0, o_v1}, 32'd1);
    chk("ind.pc_0", o_p0, 32'h100);
    chk("ind.pc_1", o_p1, 32'h104);
    chk("ind.cnt", IW'(o_cnt), 32'd0);
    chk("ind.ready", {31'b0, o_ready}, 32'd1);

    // Dependent pair splits over two cycles
    set_pair(1'b1, 1'b1, 32'h100, 32'h104, 5'd5, 1'b1);
    tick();
    idle(); #1;
    chk("dep1.pc_0", o_p0, 32'h100);
    chk("dep1.valid_1", {31'b0, o_v1}, 32'd0);
    chk("dep1.ready", {31'b0, o_ready}, 32'd0);
    tick(); #1;
    chk("dep2.valid_0", {31'b0, o_v0}, 32'd1);
    chk("dep2.pc_0", o_p0, 32'h104);
    chk("dep2.valid_1", {31'b0, o_v1}, 32'd0);
    chk("dep2.ready", {31'b0, o_ready}, 32'd1);
    chk("dep2.cnt", IW'(o_cnt), 32'd1);
    tick();

    // Write to $0 never splits
    set_pair(1'b1, 1'b1, 32'h200, 32'h204, 5'd0, 1'b1);
    tick();
    idle(); #1;
    chk("r0.valid_1", {31'b0, o_v1}, 32'd1);
    chk("r0.pc_1", o_p1, 32'h204);
    chk("r0.cnt", IW'(o_cnt), 32'd1);

    // Stall in NORMAL: a pair presented with downstream not ready is not taken
    set_pair(1'b1, 1'b1, 32'h220, 32'h224, 5'd3, 1'b0);
    rdy = 1'b0;
    tick(); #1;
    chk("nstall.pc_0", o_p0, 32'h200);
    rdy = 1'b1;
    tick();

    // Stall while split
    set_pair(1'b1, 1'b1, 32'h100, 32'h104, 5'd7, 1'b1);
    tick();
    idle(); rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("stall.pc_0", o_p0, 32'h100);
      chk("stall.ready", {31'b0, o_ready}, 32'd0);
    end
    rdy = 1'b1;
    tick(); #1;
    chk("stall.rel_pc_0", o_p0, 32'h104);
    chk("stall.cnt", IW'(o_cnt), 32'd2);
    tick();

    // Flush while split discards the held instruction
    set_pair(1'b1, 1'b1, 32'h300, 32'h304, 5'd9, 1'b1);
    tick();
    idle(); flush = 1'b1;
    tick();
    idle(); #1;
    chk("fl.valid_0", {31'b0, o_v0}, 32'd0);
    chk("fl.valid_1", {31'b0, o_v1}, 32'd0);
    chk("fl.ready", {31'b0, o_ready}, 32'd1);
    chk("fl.cnt", IW'(o_cnt), 32'd3);
    tick(); #1;
    chk("fl.no_held", {31'b0, o_v0}, 32'd0);

    // Flush together with a dependent pair: nothing accepted
    set_pair(1'b1, 1'b1, 32'h310, 32'h314, 5'd9, 1'b1);
    flush = 1'b1;
    tick();
    idle(); #1;
    chk("fldep.valid_0", {31'b0, o_v0}, 32'd0);
    chk("fldep.ready", {31'b0, o_ready}, 32'd1);

    // Lone instr2 goes to slot0
    set_pair(1'b0, 1'b1, 32'h400, 32'h404, 5'd4, 1'b1);
    tick();
    idle(); #1;
    chk("only2.valid_0", {31'b0, o_v0}, 32'd1);
    chk("only2.pc_0", o_p0, 32'h404);
    chk("only2.valid_1", {31'b0, o_v1}, 32'd0);

    // Saturation of the split counter
    for (int k = 0; k < 5; k++) begin
      set_pair(1'b1, 1'b1, 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k), 5'd2, 1'b1);
      tick();
      idle();
      tick();
    end
    #1;
    chk("sat.cnt", IW'(o_cnt), 32'd3);

    // Reset mid-split
    set_pair(1'b1, 1'b1, 32'h600, 32'h604, 5'd6, 1'b1);
    tick();
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rstsp.valid_0", {31'b0, o_v0}, 32'd0);
    chk("rstsp.pc_0", o_p0, 32'd0);
    chk("rstsp.cnt", IW'(o_cnt), 32'd0);
    chk("rstsp.ready", {31'b0, o_ready}, 32'd1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
Pairing/issue register stage that sits directly downstream of the rd/rs/rt duplicate checker (check_dup) in the superscalar front end.
- Takes a fetched instruction pair plus the checker's change_instr flag.
- Issues both instructions together when they are independent.
- When instr2 depends on instr1, splits the pair across two cycles: instr1 issues alone, then instr2 issues alone, with the fetch stage back-pressured.
- Also counts split events for performance analysis.

Parameters:
IWIDTH, 32, instruction and PC width
AWIDTH, `AWIDTH (5), register address width
CWIDTH, 16, split-event counter width

Ports:
di_i_clk  in  1  clock
di_i_rst  in  1  synchronous active-high reset
di_i_flush  in  1  pipeline flush (branch redirect)
di_i_valid_1  in  1  instr1 valid from fetch
di_i_valid_2  in  1  instr2 valid from fetch
di_i_instr_1  in  IWIDTH  instr1 word
di_i_pc_1  in  IWIDTH  instr1 PC
di_i_instr_2  in  IWIDTH  instr2 word
di_i_pc_2  in  IWIDTH  instr2 PC
di_i_addr_rd_1  in  AWIDTH  destination register of instr1
di_i_change_instr  in  1  dependency flag from check_dup
di_i_ready  in  1  downstream (decode/issue) accepts this cycle
di_o_ready  out  1  fetch may present a new pair
di_o_valid_0  out  1  slot0 valid
di_o_instr_0  out  IWIDTH  slot0 instruction
di_o_pc_0  out  IWIDTH  slot0 PC
di_o_valid_1  out  1  slot1 valid
di_o_instr_1  out  IWIDTH  slot1 instruction
di_o_pc_1  out  IWIDTH  slot1 PC
di_o_split_cnt  out  CWIDTH  saturating count of split pairs

Behaviour:
Reset (synchronous on di_i_rst = 1):
- All outputs 0, except di_o_ready = 1 after reset.
- Held buffer cleared; state NORMAL.

Qualified dependency:
- dep = di_i_change_instr & di_i_valid_1 & di_i_valid_2 & (di_i_addr_rd_1 != 0).
- A write to $0 never splits.

States: NORMAL, SPLIT. Outputs are registered, with 1-cycle latency from input accept to slot outputs.

di_o_ready:
- Combinational: (state == NORMAL) & di_i_ready & ~di_i_flush.
- Accept occurs when di_o_ready & (di_i_valid_1 | di_i_valid_2).

NORMAL state:
- Accept with dep = 0: slot0 ← instr1/pc1/valid_1 and slot1 ← instr2/pc2/valid_2. If only valid_2 is set, it is placed in slot0 and slot1 is invalid.
- Accept with dep = 1: slot0 ← instr1 (valid), slot1 invalid; instr2/pc2 latched into the hold buffer; state → SPLIT; split_cnt += 1, saturating at all-ones.
- di_i_ready = 1 with no valid input: both slot valids cleared.

SPLIT state:
- di_o_ready = 0.
- When di_i_ready = 1: slot0 ← hold buffer (valid), slot1 invalid, state → NORMAL.

Stall (di_i_ready = 0): all slot registers, hold buffer and state are held unchanged; nothing is accepted.

Flush:
- di_i_flush = 1 has priority over everything except reset.
- Next cycle: both slot valids = 0, hold buffer invalid, state = NORMAL.
- Instruction/PC data fields are don't-care. split_cnt is unchanged. No accept occurs in the flush cycle.
- A flush arriving while in SPLIT discards the held instr2.

Simultaneous events:
- Reset > flush > stall > normal operation.
- A flush in the same cycle as a dep accept: the flush wins and the counter does not increment.

Ordering: slot0 is always the older instruction; program order is never inverted.

Decomposition:
Shared package/header, alongside `AWIDTH:
- `IWIDTH
- state encodings `DI_NORMAL = 1'b0 and `DI_SPLIT = 1'b1

Sub-module dual_issue_hold: a single-entry hold register (instr, pc, valid) with load/clear. check_dup stays external and feeds di_i_change_instr.

Test Plan:
- Independent pair: pc1=0x100, pc2=0x104, change=0, rd1=5, di_i_ready=1 -> next cycle valid_0 = valid_1 = 1, pc_0 = 0x100, pc_1 = 0x104; split_cnt = 0; di_o_ready stays 1.
- Dependent pair: rd1=5, change=1 -> cycle+1: valid_0 = 1 with pc_0 = 0x100, valid_1 = 0, di_o_ready = 0; cycle+2: pc_0 = 0x104, valid_1 = 0, di_o_ready = 1; split_cnt = 1.
- $0 destination: rd1=0, change=1 -> issued as a pair with both valid and no split; split_cnt stays 0.
- Stall in SPLIT: after the dep accept, hold di_i_ready = 0 for 3 cycles -> outputs frozen at pc_0 = 0x100 and di_o_ready = 0; on release, pc_0 = 0x104 issues.
- Flush in SPLIT: dep accept, then di_i_flush = 1 -> next cycle both valids 0, di_o_ready = 1, and the held 0x104 never appears.
- Reset mid-SPLIT, plus saturation: di_i_rst = 1 while in SPLIT -> all outputs 0 and di_o_ready = 1 next cycle. With CWIDTH = 2, 5 dep pairs -> split_cnt = 3.
